mult_share_arbiter: RTL
=======================

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one multiplier.
REQ-002 SHALL have parameter TIMEOUT, default 16, max WAIT cycles before the multiplier is declared hung.
REQ-003 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 SHALL have port req_valid  in  NUM_REQ  per-requester operation request.
REQ-006 SHALL have port req_a  in  NUM_REQ*4  signed multiplicand per requester, slice i = [4i+3:4i].
REQ-007 SHALL have port req_b  in  NUM_REQ*4  signed multiplier per requester, same slicing.
REQ-008 SHALL have port req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i]&req_ready[i].
REQ-009 SHALL have port rsp_valid  out  1  result available.
REQ-010 SHALL have port rsp_ready  in  1  consumer accepts result.
REQ-011 SHALL have port rsp_id  out  $clog2(NUM_REQ)  index of requester owning the result.
REQ-012 SHALL have port rsp_data  out  8  signed product.
REQ-013 SHALL have port rsp_err  out  1  result invalid due to timeout.
REQ-014 SHALL have port mul_start  out  1  start pulse to shared sequential 4x4 signed multiplier.
REQ-015 SHALL have ports mul_x, mul_y  out  4 each  signed operands to multiplier.
REQ-016 SHALL have ports mul_z  in  8, mul_valid  in  1  multiplier product and one-cycle done pulse.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-018 IDLE: if any req_valid, SHALL assert req_ready combinationally for exactly one requester chosen round-robin, latch a, b, id, go to ISSUE; else stay, req_ready all zero.
REQ-019 Round-robin SHALL search from pointer ptr upward with wrap; on grant g, ptr <= (g+1) mod NUM_REQ; ptr reset 0.
REQ-020 req_ready SHALL be zero in every state except IDLE.
REQ-021 ISSUE: SHALL drive mul_start=1 for exactly one cycle with mul_x/mul_y = latched operands, clear timer, go to WAIT.
REQ-022 mul_x/mul_y SHALL hold latched operands through ISSUE and WAIT; mul_start zero elsewhere.
REQ-023 WAIT: on mul_valid SHALL latch mul_z into rsp_data, rsp_err<=0, go to RESP.
REQ-024 WAIT: timer increments each cycle; at timer==TIMEOUT-1 without mul_valid SHALL set rsp_data<=0, rsp_err<=1, go to RESP.
REQ-025 mul_valid coinciding with timeout cycle SHALL take priority (valid result, no error).
REQ-026 mul_valid outside WAIT SHALL be ignored.
REQ-027 RESP: rsp_valid=1 with stable rsp_id/rsp_data/rsp_err until rsp_ready; on rsp_valid&rsp_ready go to IDLE.
REQ-028 Best-case latency grant-to-rsp_valid SHALL be multiplier latency + 2 cycles (5-cycle multiplier gives 7); one operation in flight at a time.
REQ-029 rsp_data SHALL be exact 8-bit two's-complement product; no saturation.

Reset
REQ-030 On rst: state IDLE, ptr 0, timer 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_err 0, mul_start 0, mul_x 0, mul_y 0.
REQ-031 rst in any state, including mid-WAIT, SHALL abandon the operation without a response; later mul_valid ignored.

Structure
REQ-032 Package mult_arb_pkg SHALL hold state enum (IDLE, ISSUE, WAIT, RESP), OPW=4, PRODW=8.
REQ-033 Round-robin grant logic SHALL be sub-module mult_rr_arbiter (req vector, ptr in; one-hot grant, index out).
REQ-034 Multiplier SHALL be external, connected through the mul_* ports.

Verification
REQ-035 Single req0 a=3 b=-2 -> ISSUE next cycle, rsp_id=0, rsp_data=8'hFA, rsp_err=0.
REQ-036 All four req_valid held, rsp_ready=1 -> grants 0,1,2,3,0 in order; a=-8 b=-8 on req3 -> rsp_data=8'h40.
REQ-037 Model holds mul_valid low -> rsp_valid exactly TIMEOUT cycles after WAIT entry, rsp_err=1, rsp_data=0.
REQ-038 rsp_ready low 10 cycles in RESP -> outputs stable, req_ready stays 0, no new mul_start.
REQ-039 rst 2 cycles into WAIT, then mul_valid -> no rsp_valid, all outputs at reset values, ptr=0.
REQ-040 mul_valid on timeout cycle -> rsp_err=0, correct product delivered.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the multiplier-sharing arbiter.
// The state encoding is fixed so that legacy code comparing raw 2-bit values keeps working.
package mult_arb_pkg;

    localparam int OPW   = 4;
    localparam int PRODW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Successor index in a ring of n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mult_rr_arbiter.sv
// Round-robin grant: searches upward from ptr with wraparound.
// Returns a one-hot grant, the granted index, and whether anything was granted.
module mult_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx,
    output logic               any
);

    logic [IDW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Time-shares one external sequential 4x4 signed multiplier among NUM_REQ requesters.
// A single operation is in flight at a time; a hung multiplier is cut off after TIMEOUT cycles.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_REQ-1:0]                            req_valid,
    input  logic [NUM_REQ*OPW-1:0]                        req_a,
    input  logic [NUM_REQ*OPW-1:0]                        req_b,
    output logic [NUM_REQ-1:0]                            req_ready,
    output logic                                          rsp_valid,
    input  logic                                          rsp_ready,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id,
    output logic signed [PRODW-1:0]                       rsp_data,
    output logic                                          rsp_err,
    output logic                                          mul_start,
    output logic signed [OPW-1:0]                         mul_x,
    output logic signed [OPW-1:0]                         mul_y,
    input  logic signed [PRODW-1:0]                       mul_z,
    input  logic                                          mul_valid
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    state_t                state;
    logic [IDW-1:0]        ptr;
    logic [TW-1:0]         timer;
    logic signed [OPW-1:0] op_a_p0;
    logic signed [OPW-1:0] op_b_p0;

    logic [NUM_REQ-1:0]    grant;
    logic [IDW-1:0]        gnt_idx;
    logic                  gnt_any;
    logic                  take;
    logic                  timeout_hit;

    mult_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    // Grant is combinational so the transfer completes in the cycle the request is seen.
    assign take        = (state == IDLE) && gnt_any && !rst;
    assign req_ready   = take ? grant : '0;
    assign timeout_hit = (timer == TW'(TIMEOUT - 1));

    assign mul_start = (state == ISSUE);
    assign mul_x     = (state == ISSUE || state == WAIT) ? op_a_p0 : '0;
    assign mul_y     = (state == ISSUE || state == WAIT) ? op_b_p0 : '0;
    assign rsp_valid = (state == RESP);

    // Stage p0: operand capture at grant.
    always_ff @(posedge clk) begin
        if (take) begin
            op_a_p0 <= $signed(req_a[gnt_idx*OPW +: OPW]);
            op_b_p0 <= $signed(req_b[gnt_idx*OPW +: OPW]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            timer    <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        state  <= ISSUE;
                        ptr    <= IDW'(rr_next(int'(gnt_idx), NUM_REQ));
                        rsp_id <= gnt_idx;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A product arriving on the timeout cycle still wins.
                    if (mul_valid) begin
                        rsp_data <= mul_z;
                        rsp_err  <= 1'b0;
                        state    <= RESP;
                    end else if (timeout_hit) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        state    <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
